// File: rtl/burst_beat_packer_if.sv
// Beat-in / packed-word-out bundle between the narrow slice, the packer and the wide datapath.
// slave is the packer's view; master is the surrounding logic driving beats and accepting words.
interface burst_beat_packer_if #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
);
    localparam int CW = $clog2(RATIO + 1);

    logic                     src_vaild;
    logic [WIDTH-1:0]         src_data_in;
    logic                     src_ready;
    logic                     dst_vaild;
    logic [WIDTH*RATIO-1:0]   dst_data_out;
    logic [CW-1:0]            dst_cnt;
    logic                     dst_ready;
    logic                     idle;

    modport slave (
        input  src_vaild, src_data_in, dst_ready,
        output src_ready, dst_vaild, dst_data_out, dst_cnt, idle
    );

    modport master (
        output src_vaild, src_data_in, dst_ready,
        input  src_ready, dst_vaild, dst_data_out, dst_cnt, idle
    );
endinterface

// File: rtl/burst_beat_packer.sv
// Packs RATIO WIDTH-bit beats (beat 0 = LSB) into one registered wide word; optional PACK_FLUSH_EN flushes partial words.
// Latency: word valid the cycle after its completing beat is accepted; 1 beat/cycle sustained, no bubble.
// Backpressure: only the completing beat stalls, and only while the held word is not being drained.
module burst_beat_packer #(
    parameter int WIDTH    = 8,
    parameter int RATIO    = 4,
    parameter int IDLE_CYC = 8
) (
    input  logic                 clk,
    input  logic                 s_rst_n,
    burst_beat_packer_if.slave   bus
);
    localparam int CW  = $clog2(RATIO + 1);
    localparam int ICW = $clog2(IDLE_CYC + 1);
    localparam int PW  = WIDTH * (RATIO - 1);

    // Control state is carried by bcnt and the output valid; PACK and HOLD may overlap.
    typedef enum logic [1:0] {
        ST_EMPTY     = 2'b00,
        ST_HOLD      = 2'b01,
        ST_PACK      = 2'b10,
        ST_PACK_HOLD = 2'b11
    } state_t;

    logic [CW-1:0]          bcnt_q,  bcnt_nxt;
    logic [PW-1:0]          pack_q,  pack_nxt;
    logic                   vld_q,   vld_nxt;
    logic [WIDTH*RATIO-1:0] data_q,  data_nxt;
    logic [CW-1:0]          cnt_q,   cnt_nxt;
    logic [ICW-1:0]         icnt_q,  icnt_nxt;
    logic                   idle_q,  idle_nxt;

    state_t state;
    logic   last_beat;
    logic   stall;
    logic   src_rdy;
    logic   accept;
    logic   out_free;
    logic   flush;

    always_comb begin
        state = state_t'({(bcnt_q != '0), vld_q});
    end

    assign last_beat = (bcnt_q == CW'(RATIO - 1));
    assign stall     = (state == ST_PACK_HOLD) && last_beat && !bus.dst_ready;
    assign src_rdy   = s_rst_n & ~stall;
    assign accept    = bus.src_vaild & src_rdy;
    assign out_free  = !vld_q || bus.dst_ready;

`ifdef PACK_FLUSH_EN
    // A beat arriving on the trigger cycle wins; the flush waits for a quiet cycle.
    assign flush = (bcnt_q != '0) && (icnt_q == ICW'(IDLE_CYC)) && !bus.src_vaild && out_free;
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        bcnt_nxt = bcnt_q;
        pack_nxt = pack_q;
        vld_nxt  = vld_q;
        data_nxt = data_q;
        cnt_nxt  = cnt_q;
        icnt_nxt = icnt_q;
        idle_nxt = 1'b0;

        if (vld_q && bus.dst_ready) begin
            vld_nxt = 1'b0;
        end

        if (accept) begin
            if (last_beat) begin
                data_nxt = {bus.src_data_in, pack_q};
                cnt_nxt  = CW'(RATIO);
                vld_nxt  = 1'b1;
                bcnt_nxt = '0;
                pack_nxt = '0;
            end else begin
                for (int k = 0; k < RATIO - 1; k++) begin
                    if (bcnt_q == CW'(k)) begin
                        pack_nxt[k*WIDTH +: WIDTH] = bus.src_data_in;
                    end
                end
                bcnt_nxt = bcnt_q + CW'(1);
            end
        end else if (flush) begin
            // pack is cleared on every word boundary, so unfilled upper beats are already zero
            data_nxt = {{WIDTH{1'b0}}, pack_q};
            cnt_nxt  = bcnt_q;
            vld_nxt  = 1'b1;
            bcnt_nxt = '0;
            pack_nxt = '0;
        end

        if (bus.src_vaild) begin
            icnt_nxt = '0;
        end else if (icnt_q != ICW'(IDLE_CYC)) begin
            icnt_nxt = icnt_q + ICW'(1);
        end

        // Built from next-state values so idle drops on the same edge that sees src_vaild.
        idle_nxt = (icnt_nxt == ICW'(IDLE_CYC)) && (bcnt_nxt == '0) && !vld_nxt;
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            bcnt_q <= '0;
            pack_q <= '0;
            vld_q  <= 1'b0;
            data_q <= '0;
            cnt_q  <= '0;
            icnt_q <= '0;
            idle_q <= 1'b0;
        end else begin
            bcnt_q <= bcnt_nxt;
            pack_q <= pack_nxt;
            vld_q  <= vld_nxt;
            data_q <= data_nxt;
            cnt_q  <= cnt_nxt;
            icnt_q <= icnt_nxt;
            idle_q <= idle_nxt;
        end
    end

    assign bus.src_ready    = src_rdy;
    assign bus.dst_vaild    = vld_q;
    assign bus.dst_data_out = data_q;
    assign bus.dst_cnt      = cnt_q;
    assign bus.idle         = idle_q;
endmodule
